// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared FPU issue typedefs: instruction format, default requester count and index type.
// Imported by fpu_issue_arbiter and its round-robin picker.
package fpu_issue_arbiter_pkg;

    localparam int NUM_FPU_REQ   = 2;
    localparam int FPU_REQ_IDX_W = (NUM_FPU_REQ > 1) ? $clog2(NUM_FPU_REQ) : 1;

    typedef logic [FPU_REQ_IDX_W-1:0] FpuReqIdx;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [7:0] tag;
    } FpuInstr;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } StageState;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fpu_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = NUM_FPU_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin arbiter feeding one registered FPU issue slot from NUM_REQ requesters.
// Define FPU_ARB_PERF_EN to build the perf_grant/perf_stall counters; otherwise they read 0.
module fpu_issue_arbiter
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = NUM_FPU_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flash,
    input  logic [NUM_REQ-1:0]        req_en,
    input  FpuInstr [NUM_REQ-1:0]     req_msg,
    output logic [NUM_REQ-1:0]        req_reject,
    output logic                      out_en,
    output FpuInstr                   out_msg,
    input  logic                      out_reject,
    output logic [IDX_W-1:0]          out_src,
    output logic [NUM_REQ-1:0][31:0]  perf_grant,
    output logic [31:0]               perf_stall
);

    StageState          state_q, state_d;
    FpuInstr            msg_q, msg_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   rr_q, rr_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               can_accept;
    logic               accept;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_en),
        .ptr   (rr_q),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    // A full slot can be refilled in the same cycle it drains.
    assign can_accept = ~flash & ((state_q == STAGE_EMPTY) | ~out_reject);
    assign accept     = can_accept & grant_valid;
    assign req_reject = accept ? ~grant : '1;

    assign out_en  = (state_q == STAGE_FULL) & ~flash;
    assign out_msg = msg_q;
    assign out_src = src_q;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (flash) begin
            state_d = STAGE_EMPTY;
        end else if (accept) begin
            state_d = STAGE_FULL;
            msg_d   = req_msg[grant_idx];
            src_d   = grant_idx;
            rr_d    = IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
        end else if (state_q == STAGE_FULL && !out_reject) begin
            state_d = STAGE_EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STAGE_EMPTY;
            msg_q   <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

`ifdef FPU_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    // Counters wrap naturally and survive flash; only reset clears them.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && grant[i]) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
            end
        end
        stall_cnt_d = stall_cnt_q + ((out_en && out_reject) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant = grant_cnt_q;
    assign perf_stall = stall_cnt_q;
`else
    assign perf_grant = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the issue slot.
module tb_fpu_issue_arbiter;
    import fpu_issue_arbiter_pkg::*;

    localparam int N = NUM_FPU_REQ;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flash;
    logic [N-1:0]         req_en;
    FpuInstr [N-1:0]      req_msg;
    logic [N-1:0]         req_reject;
    logic                 out_en;
    FpuInstr              out_msg;
    logic                 out_reject;
    FpuReqIdx             out_src;
    logic [N-1:0][31:0]   perf_grant;
    logic [31:0]          perf_stall;

    int total = 0;
    int bad   = 0;

    // Reference model: the issue slot as a queue holding zero or one instruction.
    int          rr;
    FpuInstr     stage_msg[$];
    int          stage_src[$];
    int unsigned grants[N];
    int unsigned stalls;
    bit          held[N];

    fpu_issue_arbiter #(.NUM_REQ(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .flash      (flash),
        .req_en     (req_en),
        .req_msg    (req_msg),
        .req_reject (req_reject),
        .out_en     (out_en),
        .out_msg    (out_msg),
        .out_reject (out_reject),
        .out_src    (out_src),
        .perf_grant (perf_grant),
        .perf_stall (perf_stall)
    );

    always #5 clock = ~clock;

    function automatic FpuInstr randInstr();
        FpuInstr m;
        m.op  = 5'($urandom);
        m.rm  = 3'($urandom);
        m.rd  = 5'($urandom);
        m.rs1 = 5'($urandom);
        m.rs2 = 5'($urandom);
        m.tag = 8'($urandom);
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        rr = 0;
        stage_msg.delete();
        stage_src.delete();
        stalls = 0;
        for (int i = 0; i < N; i++) begin
            grants[i] = 0;
            held[i]   = 1'b0;
        end
    endtask

    task automatic checkPerf();
        for (int i = 0; i < N; i++) begin
`ifdef FPU_ARB_PERF_EN
            checkOutput($sformatf("perf_grant%0d", i), 64'(perf_grant[i]), 64'(grants[i]));
`else
            checkOutput($sformatf("perf_grant%0d", i), 64'(perf_grant[i]), 64'd0);
`endif
        end
`ifdef FPU_ARB_PERF_EN
        checkOutput("perf_stall", 64'(perf_stall), 64'(stalls));
`else
        checkOutput("perf_stall", 64'(perf_stall), 64'd0);
`endif
    endtask

    // One clock: drive at negedge, check combinational view, advance model, wait posedge.
    task automatic applyStimulus(input logic [N-1:0] en, input logic rej, input logic fl);
        bit           full;
        bit           exp_en;
        bit           can;
        int           win;
        int           c;
        logic [N-1:0] exp_rej;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (!held[i]) req_msg[i] = randInstr();
        end
        req_en     = en;
        out_reject = rej;
        flash      = fl;
        #1;
        full   = (stage_msg.size() != 0);
        exp_en = full && !fl;
        can    = !fl && (!full || !rej);
        win    = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                c = (rr + k) % N;
                if (win < 0 && en[c]) win = c;
            end
        end
        exp_rej = '1;
        if (win >= 0) exp_rej[win] = 1'b0;
        checkOutput("out_en", 64'(out_en), 64'(exp_en));
        checkOutput("req_reject", 64'(req_reject), 64'(exp_rej));
        if (exp_en) begin
            checkOutput("out_msg", 64'(out_msg), 64'(stage_msg[0]));
            checkOutput("out_src", 64'(out_src), 64'(stage_src[0]));
        end
        checkPerf();
        if (exp_en && rej) stalls++;
        if (fl) begin
            stage_msg.delete();
            stage_src.delete();
        end else if (win >= 0) begin
            stage_msg.delete();
            stage_src.delete();
            stage_msg.push_back(req_msg[win]);
            stage_src.push_back(win);
            rr = (win + 1) % N;
            grants[win]++;
        end else if (full && !rej) begin
            stage_msg.delete();
            stage_src.delete();
        end
        for (int i = 0; i < N; i++) held[i] = en[i] && (i != win);
        @(posedge clock);
    endtask

    task automatic randomStep();
        logic [N-1:0] en;
        for (int i = 0; i < N; i++) en[i] = held[i] ? 1'b1 : 1'($urandom_range(0, 1));
        applyStimulus(en, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    endtask

    initial begin
        reset      = 1'b1;
        flash      = 1'b0;
        req_en     = '0;
        out_reject = 1'b0;
        for (int i = 0; i < N; i++) req_msg[i] = randInstr();
        modelReset();
        #12;
        checkOutput("rst_out_en", 64'(out_en), 64'd0);
        checkOutput("rst_out_src", 64'(out_src), 64'd0);
        checkOutput("rst_out_msg", 64'(out_msg), 64'd0);
        checkPerf();
        @(negedge clock);
        reset = 1'b0;

        // Both requesters busy: alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Single requester streams back to back.
        for (int i = 0; i < 5; i++) applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Held slot under back-pressure, then drain-and-refill.
        applyStimulus(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Flush while full and both requesting.
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Asynchronous reset between edges while full, pointer away from 0.
        applyStimulus(2'b01, 1'b0, 1'b0);
        #2;
        reset  = 1'b1;
        req_en = '0;
        flash  = 1'b0;
        #1;
        checkOutput("async_rst_out_en", 64'(out_en), 64'd0);
        checkOutput("async_rst_out_src", 64'(out_src), 64'd0);
        checkOutput("async_rst_out_msg", 64'(out_msg), 64'd0);
        modelReset();
        checkPerf();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(2'b11, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) randomStep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
